// File: rtl/reaction_seq.sv
// reaction_seq: reaction-timer game sequencer. Waits a pseudo-random delay,
// lights one of four LEDs and times the player's response in 1 ms ticks.
module reaction_seq #(
  parameter int TICK_DIV     = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int MAX_MS       = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  btn,
  output logic [1:0]  led_sel,
  output logic        led_on,
  output logic        busy,
  output logic [13:0] react_ms,
  output logic [1:0]  result_code,
  output logic        result_valid
);
  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [13:0]   MAX_CNT   = 14'(MAX_MS);
  localparam logic [13:0]   MIN_DLY   = 14'(MIN_DELAY_MS);

  localparam logic [1:0] RES_OK      = 2'b00;
  localparam logic [1:0] RES_EARLY   = 2'b01;
  localparam logic [1:0] RES_WRONG   = 2'b10;
  localparam logic [1:0] RES_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_LIT, ST_DONE} state_e;

  state_e        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [13:0]   delay_q, delay_d;
  logic [1:0]    target_q, target_d;
  logic [13:0]   react_q, react_d;
  logic [1:0]    code_q, code_d;
  logic          valid_q, valid_d;

  logic          tick;
  logic [3:0]    target_onehot;
  logic [13:0]   react_inc;

  assign tick          = (presc_q == TICK_LAST);
  assign target_onehot = 4'b0001 << target_q;
  assign react_inc     = react_q + 14'd1;

  always_comb begin
    // NOTE: every signal gets a default here so no path can infer a latch.
    state_d  = state_q;
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    presc_d  = tick ? '0 : presc_q + PW'(1);
    delay_d  = delay_q;
    target_d = target_q;
    react_d  = react_q;
    code_d   = code_q;
    valid_d  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          delay_d  = MIN_DLY + {3'b000, lfsr_q[10:0]};
          target_d = lfsr_q[12:11];
          presc_d  = '0;
          react_d  = '0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (|btn) begin
          state_d = ST_DONE;
          code_d  = RES_EARLY;
          react_d = '0;
          valid_d = 1'b1;
        end else if (tick) begin
          // The tick that consumes the last ms lights the LED next cycle.
          if (delay_q <= 14'd1) begin
            delay_d = '0;
            presc_d = '0;
            state_d = ST_LIT;
          end else begin
            delay_d = delay_q - 14'd1;
          end
        end
      end
      ST_LIT: begin
        // A press outranks a coincident tick, so the count is not bumped.
        if (|btn) begin
          state_d = ST_DONE;
          code_d  = (btn == target_onehot) ? RES_OK : RES_WRONG;
          valid_d = 1'b1;
        end else if (tick) begin
          if (react_inc >= MAX_CNT) begin
            react_d = MAX_CNT;
            code_d  = RES_TIMEOUT;
            state_d = ST_DONE;
            valid_d = 1'b1;
          end else begin
            react_d = react_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= 16'hACE1;
      presc_q  <= '0;
      delay_q  <= '0;
      target_q <= '0;
      react_q  <= '0;
      code_q   <= RES_OK;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      presc_q  <= presc_d;
      delay_q  <= delay_d;
      target_q <= target_d;
      react_q  <= react_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
    end
  end

  assign led_sel      = target_q;
  assign led_on       = (state_q == ST_LIT);
  assign busy         = (state_q == ST_WAIT) || (state_q == ST_LIT);
  assign react_ms     = react_q;
  assign result_code  = code_q;
  assign result_valid = valid_q;

endmodule
